// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux_sel_pipe selector and its skid buffer.
package mux_sel_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  localparam int unsigned ERR_CNT_W = 16;

  // Smallest selector width that can encode every input plus the constant code.
  function automatic int unsigned min_sel_w(input int unsigned n_inputs);
    return $clog2(n_inputs + 1);
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides; in_ready depends only on registered state.
module mux_skid_buf
  import mux_sel_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  buf_state_e    state_q, state_d;
  logic          in_ready_q, out_valid_q;
  logic          in_ready_d, out_valid_d;
  logic [PW-1:0] out_q, skid_q;
  logic          acc, emt;
  logic          load_out_in, load_out_skid, load_skid;

  assign acc       = in_valid && in_ready_q;
  assign emt       = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  // State and handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (acc) state_d = ONE;
      ONE: begin
        if (acc && !emt)      state_d = TWO;
        else if (!acc && emt) state_d = EMPTY;
      end
      TWO:     if (emt) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Load controls and next handshake flags.
  always_comb begin
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: load_out_in = acc;
      ONE: begin
        load_out_in = acc && emt;
        load_skid   = acc && !emt;
      end
      TWO:     load_out_skid = emt;
      default: ;
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // Payload registers; output holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in)        out_q <= in_data;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= in_data;
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N:1 datapath selector with constant code, range flagging and skid-buffered output.
// Optional saturating error counter when MUX_SEL_ERR_CNT_EN is defined.
module mux_sel_pipe
  import mux_sel_pkg::*;
#(
  parameter int unsigned           WIDTH     = 32,
  parameter int unsigned           N_INPUTS  = 7,
  parameter int unsigned           SEL_W     = 3,
  parameter logic [WIDTH-1:0]      CONST_VAL = WIDTH'(227)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          selector,
  input  logic [N_INPUTS*WIDTH-1:0] data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          out_sel,
`ifdef MUX_SEL_ERR_CNT_EN
  input  logic                      err_clr,
  output logic [ERR_CNT_W-1:0]      err_count,
`endif
  output logic                      sel_err
);

  localparam int unsigned PW = 1 + SEL_W + WIDTH;

  generate
    if (SEL_W < min_sel_w(N_INPUTS)) begin : g_bad_sel_w
      $error("mux_sel_pipe: SEL_W too small for N_INPUTS");
    end
    if (N_INPUTS < 2 || N_INPUTS > 15) begin : g_bad_n
      $error("mux_sel_pipe: N_INPUTS must be 2..15");
    end
  endgenerate

  logic [WIDTH-1:0] sel_data_c;
  logic             sel_err_c;
  logic [PW-1:0]    payload_in, payload_out;

  // Source selection; codes above the constant code fall back to input 0.
  always_comb begin
    sel_data_c = data_in[WIDTH-1:0];
    sel_err_c  = 1'b0;
    if (selector == SEL_W'(N_INPUTS)) begin
      sel_data_c = CONST_VAL;
    end else if (selector > SEL_W'(N_INPUTS)) begin
      sel_err_c = 1'b1;
    end else begin
      for (int k = 0; k < int'(N_INPUTS); k++) begin
        if (selector == SEL_W'(k)) sel_data_c = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign payload_in = {sel_err_c, selector, sel_data_c};

  mux_skid_buf #(.PW(PW)) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (payload_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (payload_out)
  );

  assign {sel_err, out_sel, data_out} = payload_out;

`ifdef MUX_SEL_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Saturating count of out-of-range accepts; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (in_valid && in_ready && sel_err_c && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed self-checking bench for mux_sel_pipe (default build and N_INPUTS=5 instance).
module tb_mux_sel_pipe;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, out_ready;
  logic [2:0]    selector;
  logic [223:0]  data_in;
  logic          in_ready, out_valid, sel_err;
  logic [31:0]   data_out;
  logic [2:0]    out_sel;

  logic          in_valid5, out_ready5;
  logic [2:0]    selector5;
  logic [159:0]  data_in5;
  logic          in_ready5, out_valid5, sel_err5;
  logic [31:0]   data_out5;
  logic [2:0]    out_sel5;
`ifdef MUX_SEL_ERR_CNT_EN
  logic          err_clr, err_clr5;
  logic [15:0]   err_count, err_count5;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_sel_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .selector(selector), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .out_sel(out_sel),
`ifdef MUX_SEL_ERR_CNT_EN
    .err_clr(err_clr), .err_count(err_count),
`endif
    .sel_err(sel_err)
  );

  mux_sel_pipe #(.N_INPUTS(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .selector(selector5), .data_in(data_in5), .out_valid(out_valid5),
    .out_ready(out_ready5), .data_out(data_out5), .out_sel(out_sel5),
`ifdef MUX_SEL_ERR_CNT_EN
    .err_clr(err_clr5), .err_count(err_count5),
`endif
    .sel_err(sel_err5)
  );

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; selector = 3'd2; out_ready = 1'b1;
    in_valid5 = 1'b0; selector5 = 3'd0; out_ready5 = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out got %h want 0", data_out); end
    checks++; if ({sel_err, out_sel} !== 4'h0) begin errors++; $display("FAIL rst_sel got %h want 0", {sel_err, out_sel}); end
    in_valid = 1'b0;
    reset_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle2_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_in_range();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; selector = 3'(k);
      step();
      checks++;
      if (out_valid !== 1'b1 || data_out !== 32'(32'h1000 + k) || sel_err !== 1'b0 ||
          out_sel !== 3'(k) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_range[%0d] got v=%b d=%h e=%b s=%0d r=%b want v=1 d=%h e=0 s=%0d r=1",
                 k, out_valid, data_out, sel_err, out_sel, in_ready, 32'(32'h1000 + k), k);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL in_range_drain got %b want 0", out_valid); end
  endtask

  task automatic test_const_err();
    in_valid = 1'b1; selector = 3'd7;
    step();
    in_valid = 1'b0;
    checks++;
    if (data_out !== 32'd227 || sel_err !== 1'b0 || out_sel !== 3'd7 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL const7 got d=%0d e=%b s=%0d v=%b want d=227 e=0 s=7 v=1", data_out, sel_err, out_sel, out_valid);
    end
    in_valid5 = 1'b1; selector5 = 3'd6;
    step();
    checks++;
    if (data_out5 !== 32'h2000 || sel_err5 !== 1'b1 || out_sel5 !== 3'd6) begin
      errors++;
      $display("FAIL err6 got d=%h e=%b s=%0d want d=2000 e=1 s=6", data_out5, sel_err5, out_sel5);
    end
    selector5 = 3'd5;
    step();
    checks++;
    if (data_out5 !== 32'd227 || sel_err5 !== 1'b0 || out_sel5 !== 3'd5) begin
      errors++;
      $display("FAIL const5 got d=%0d e=%b s=%0d want d=227 e=0 s=5", data_out5, sel_err5, out_sel5);
    end
    selector5 = 3'd3;
    step();
    checks++;
    if (data_out5 !== 32'h2003 || sel_err5 !== 1'b0) begin
      errors++;
      $display("FAIL in5_3 got d=%h e=%b want d=2003 e=0", data_out5, sel_err5);
    end
    in_valid5 = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; selector = 3'd1;
    step();
    checks++; if (in_ready !== 1'b1 || data_out !== 32'h1001) begin errors++; $display("FAIL bp_first got r=%b d=%h want r=1 d=1001", in_ready, data_out); end
    selector = 3'd2;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got r=%b want 0", in_ready); end
    selector = 3'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || data_out !== 32'h1001 || out_sel !== 3'd1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d r=%b want v=1 d=1001 s=1 r=0", i, out_valid, data_out, out_sel, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    checks++; if (data_out !== 32'h1002 || out_sel !== 3'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got d=%h s=%0d r=%b want d=1002 s=2 r=1", data_out, out_sel, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== 32'h1003 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got d=%h v=%b want d=1003 v=1", data_out, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; selector = 3'd4;
    step();
    selector = 3'd5;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mr_fill got r=%b v=%b want r=0 v=1", in_ready, out_valid); end
    reset_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 32'h0 || out_sel !== 3'd0) begin
      errors++;
      $display("FAIL mr_async got v=%b r=%b d=%h s=%0d want v=0 r=1 d=0 s=0", out_valid, in_ready, data_out, out_sel);
    end
    #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_after1 got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0 || data_out !== 32'h0) begin errors++; $display("FAIL mr_after2 got v=%b d=%h want v=0 d=0", out_valid, data_out); end
  endtask

`ifdef MUX_SEL_ERR_CNT_EN
  task automatic test_err_count();
    out_ready5 = 1'b1; err_clr5 = 1'b0;
    in_valid5 = 1'b1; selector5 = 3'd7;
    for (int i = 0; i < 3; i++) step();
    in_valid5 = 1'b0;
    checks++; if (err_count5 !== 16'd3) begin errors++; $display("FAIL cnt3 got %0d want 3", err_count5); end
    in_valid5 = 1'b1; err_clr5 = 1'b1;
    step();
    in_valid5 = 1'b0; err_clr5 = 1'b0;
    checks++; if (err_count5 !== 16'd0) begin errors++; $display("FAIL cnt_clr got %0d want 0", err_count5); end
    in_valid5 = 1'b1; selector5 = 3'd6;
    for (int i = 0; i < 65534; i++) step();
    checks++; if (err_count5 !== 16'hFFFE) begin errors++; $display("FAIL cnt_fffe got %h want fffe", err_count5); end
    step();
    step();
    in_valid5 = 1'b0;
    checks++; if (err_count5 !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h want ffff", err_count5); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL cnt_dut7 got %0d want 0", err_count); end
  endtask
`endif

  initial begin
    for (int k = 0; k < 7; k++) data_in[k*32 +: 32] = 32'(32'h1000 + k);
    for (int k = 0; k < 5; k++) data_in5[k*32 +: 32] = 32'(32'h2000 + k);
`ifdef MUX_SEL_ERR_CNT_EN
    err_clr = 1'b0; err_clr5 = 1'b0;
`endif
    test_reset();
    test_in_range();
    test_const_err();
    test_backpressure();
    test_mid_reset();
`ifdef MUX_SEL_ERR_CNT_EN
    test_err_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised, registered N:1 datapath selector for the multicycle CPU datapath.
- Generalises the fixed 32-bit selector muxes:
  - WIDTH and input count are parameters.
  - One selector code maps to a programmable constant.
  - Out-of-range selectors are flagged.
  - The result is buffered behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between datapath sources (PC, ALUOut, MDR, regfile A/B, shifter) and a consuming register or unit that can stall.

Parameters:
- WIDTH, 32, data width of every input and the output.
- N_INPUTS, 7, number of data inputs (2..15).
- SEL_W, 3, selector width; must satisfy 2**SEL_W > N_INPUTS. Elaboration-time error otherwise.
- CONST_VAL, 227, WIDTH-bit value returned when selector == N_INPUTS.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  selector/data beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- selector  in  SEL_W  source select for the beat.
- data_in  in  N_INPUTS*WIDTH  flattened inputs; input k is data_in[k*WIDTH +: WIDTH].
- out_valid  out  1  data_out holds a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- data_out  out  WIDTH  selected value.
- out_sel  out  SEL_W  selector that produced data_out.
- sel_err  out  1  data_out came from an out-of-range selector.

Behaviour:
- Accept when in_valid && in_ready at the rising edge. Emit when out_valid && out_ready.
- Selection is evaluated at the accept edge; data_in is sampled only at that edge.
  - selector < N_INPUTS -> input[selector], sel_err=0.
  - selector == N_INPUTS -> CONST_VAL, sel_err=0.
  - selector > N_INPUTS -> input 0, sel_err=1.
- Latency: an accepted beat appears on data_out the cycle after acceptance, when the buffer was empty or is draining.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - TWO: out_valid=1, in_ready=0.
- Transitions (acc=accept, emt=emit):
  - EMPTY: acc -> ONE.
  - ONE: acc&!emt -> TWO; !acc&emt -> EMPTY; acc&emt -> ONE, output replaced by the new beat.
  - TWO: emt -> ONE, skid entry moves to output; no accept is possible.
- in_ready is derived from the state register only, never combinationally from out_ready.
- data_out, out_sel and sel_err stay stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Reset (reset_n=0, async, at any time, including mid-transfer):
  - state=EMPTY, out_valid=0, data_out=0, out_sel=0, sel_err=0, skid contents=0.
  - in_ready=1, but no accept occurs while reset_n=0.
  - Any in-flight beats are discarded.
- Deassertion: first accept possible on the first rising edge with reset_n=1.

Optional Feature:
- Macro MUX_SEL_ERR_CNT_EN.
- Defined:
  - Adds output port err_count, 16 bits, reset 0.
  - Increments by 1 on each accept with selector > N_INPUTS.
  - Saturates at 16'hFFFF.
  - Adds input err_clr (1 bit, sync): zeroes the counter, and takes priority over an increment in the same cycle.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Package mux_sel_pkg:
  - Buffer state encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Counter width constant ERR_CNT_W=16.
  - Function computing the minimum legal SEL_W from N_INPUTS.
- Sub-module mux_skid_buf, parametrised by payload width:
  - Carries {sel_err, out_sel, data} as one payload.
  - Implements the state machine and handshake.
- The top level holds the selection/constant/error logic and the optional counter.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles, then release -> out_valid=0, data_out=0, in_ready=1; no spurious output.
- In-range selection: inputs k=0..6 = 32'h1000+k, out_ready=1, selectors 0..6 back-to-back -> data_out 32'h1000..32'h1006 one cycle after each accept; throughput 1/cycle; sel_err=0.
- Constant and error codes:
  - selector=7 (N_INPUTS=7) -> data_out=227, sel_err=0.
  - Re-elaborate with N_INPUTS=5; selector=6 -> data_out=input0, sel_err=1, out_sel=6.
- Backpressure: out_ready=0 while offering 3 beats -> 2 accepted, in_ready=0 after the second; hold 4 cycles -> outputs stable; release -> beats emerge in order, third accepted next cycle.
- Mid-transfer reset: state TWO, pulse reset_n low between edges -> out_valid drops immediately; after release no old beat reappears.
- MUX_SEL_ERR_CNT_EN:
  - 3 out-of-range accepts -> err_count=3.
  - err_clr asserted with a simultaneous error accept -> err_count=0.
  - Preload 16'hFFFE, then 2 out-of-range accepts -> err_count=16'hFFFF.
